sync_req_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (for example a shared SPI/DAC command path) among `N_REQ` requesters whose request lines are asynchronous to `clk`. The request vector passes through one internal `synchronizer` instance (WIDTH=`N_REQ`). A new grant is issued only while the synchronizer reports the vector stable. A per-grant watchdog revokes grants that are held too long and locks out the offending requester until it drops its request.

---
 rtl/sync_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sync_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous request lines: requests are synchronized,
// grants are issued only on a stable vector, and a watchdog revokes long grants.

module synchronizer #(
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 2,
  parameter int STABLE_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             stable
);
  localparam int D  = (DEPTH < 2) ? 2 : DEPTH;
  localparam int S  = (STABLE_COUNT < 1) ? 1 : STABLE_COUNT;
  localparam int CW = $clog2(S + 2);

  logic [D-1:0][WIDTH-1:0] chain_q;
  logic [CW-1:0]           cnt_q, cnt_d;

  // The count restarts on every edge where dout changes and saturates one past
  // S, so stable rises S+1 edges after the last change of dout.
  always_comb begin
    cnt_d = cnt_q;
    if (chain_q[D-2] != chain_q[D-1]) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(S + 1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      cnt_q   <= '0;
    end else begin
      chain_q <= {chain_q[D-2:0], din};
      cnt_q   <= cnt_d;
    end
  end

  assign dout   = chain_q[D-1];
  assign stable = (cnt_q == CW'(S + 1));
endmodule

module sync_req_arbiter #(
  parameter int N_REQ        = 4,
  parameter int SYNC_DEPTH   = 2,
  parameter int STABLE_COUNT = 2,
  parameter int MAX_GRANT    = 1024,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_REQ-1:0]                         req_async,
  output logic [N_REQ-1:0]                         grant,
  output logic                                     grant_valid,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                     timeout,
  output logic [N_REQ-1:0]                         lockout
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW  = (MAX_GRANT > 0) ? $clog2(MAX_GRANT + 1) : 1;
  localparam int GAP = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW  = $clog2(GAP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, lockout_q, lockout_d;
  logic [IDW-1:0]   grantId_q, grantId_d, last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             timeout_q, timeout_d, grantValid_q;
  logic [N_REQ-1:0] sreq, eligible;
  logic             sstable, winFound;
  logic [IDW-1:0]   winIdx, cand;

  synchronizer #(
    .WIDTH       (N_REQ),
    .DEPTH       (SYNC_DEPTH),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (req_async),
    .dout  (sreq),
    .stable(sstable)
  );

  assign eligible = sreq & ~lockout_q;

  // Scan upward from the requester after the last winner, wrapping modulo N_REQ.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % N_REQ);
      if (!winFound && eligible[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grantId_d = grantId_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    lockout_d = lockout_q & sreq;
    case (state_q)
      ST_IDLE: begin
        if (sstable && winFound) begin
          grant_d         = '0;
          grant_d[winIdx] = 1'b1;
          grantId_d       = winIdx;
          last_d          = winIdx;
          hold_d          = HW'(1);
          state_d         = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A release on the same edge as the watchdog limit takes priority.
        if (!sreq[grantId_q]) begin
          grant_d   = '0;
          grantId_d = '0;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (MAX_GRANT != 0 && hold_q == HW'(MAX_GRANT)) begin
          grant_d              = '0;
          grantId_d            = '0;
          gap_d                = '0;
          timeout_d            = 1'b1;
          lockout_d[grantId_q] = 1'b1;
          state_d              = ST_GAP;
        end else if (MAX_GRANT != 0 && hold_q != HW'(MAX_GRANT)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grantId_q    <= '0;
      last_q       <= IDW'(N_REQ - 1);
      hold_q       <= '0;
      gap_q        <= '0;
      timeout_q    <= 1'b0;
      lockout_q    <= '0;
      grantValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grantId_q    <= grantId_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      timeout_q    <= timeout_d;
      lockout_q    <= lockout_d;
      grantValid_q <= |grant_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grantValid_q;
  assign grant_id    = grantId_q;
  assign timeout     = timeout_q;
  assign lockout     = lockout_q;
endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench for sync_req_arbiter: a scoreboard of expected grant ids
// plus directed latency, stability, watchdog and reset checks.

module tb_sync_req_arbiter;
  localparam int N    = 4;
  localparam int MAXG = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant, lockout;
  logic         grantValid, timeout;
  logic [1:0]   grantId;

  int           checks = 0;
  int           fails = 0;
  int           toCount = 0;
  int           tcBefore;
  int           expId;
  int           sbQ[$];
  logic [N-1:0] prevGrant = '0;
  logic         anyValid;
  int           held;

  sync_req_arbiter #(
    .N_REQ(N), .SYNC_DEPTH(2), .STABLE_COUNT(2), .MAX_GRANT(MAXG), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .req_async(req), .grant(grant), .grant_valid(grantValid),
    .grant_id(grantId), .timeout(timeout), .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input int expectId);
    req = v;
    if (expectId >= 0) sbQ.push_back(expectId);
  endtask

  task automatic waitGrant(input string tag, input int budget);
    for (int i = 0; i < budget && !grantValid; i++) tick();
    checkOutput(tag, grantValid, 1);
  endtask

  task automatic waitRelease(input string tag, input int budget);
    for (int i = 0; i < budget && grantValid; i++) tick();
    checkOutput(tag, grantValid, 0);
  endtask

  // Scoreboard monitor: every new grant pops one expected id.
  always @(negedge clk) begin
    if (timeout) toCount++;
    if (!rst && grant !== prevGrant) begin
      if (grant !== '0) begin
        checkOutput("mon_no_overlap", prevGrant, 0);
        checkOutput("mon_onehot", $onehot(grant), 1);
        checkOutput("mon_valid_hi", grantValid, 1);
        checkOutput("sb_has_expect", sbQ.size() > 0, 1);
        if (sbQ.size() > 0) begin
          expId = sbQ.pop_front();
          checkOutput("sb_grant_id", grantId, expId);
          checkOutput("sb_grant_vec", grant, 1 << expId);
        end
      end else begin
        checkOutput("mon_valid_lo", grantValid, 0);
        checkOutput("mon_id_zero", grantId, 0);
      end
    end
    prevGrant = grant;
  end

  initial begin
    // Reset values
    tick();
    tick();
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_valid", grantValid, 0);
    checkOutput("rst_id", grantId, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_lockout", lockout, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Single request: grant on the 6th edge, release two edges after the drop
    applyStimulus(4'b0001, 0);
    repeat (5) tick();
    checkOutput("t1_no_grant_e4", grant, 0);
    tick();
    checkOutput("t1_grant_e5", grant, 4'b0001);
    checkOutput("t1_id_e5", grantId, 0);
    checkOutput("t1_valid_e5", grantValid, 1);
    repeat (3) tick();
    applyStimulus(4'b0000, -1);
    tick();
    tick();
    checkOutput("t1_hold_f1", grant, 4'b0001);
    tick();
    checkOutput("t1_release_f2", grant, 0);
    checkOutput("t1_valid_f2", grantValid, 0);
    repeat (5) tick();

    // Round robin with all four requesting, starting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    applyStimulus(4'b1111, 0);
    sbQ.push_back(1);
    sbQ.push_back(2);
    sbQ.push_back(3);
    sbQ.push_back(0);
    begin : rr
      int   dropCnt[N];
      int   raiseCnt[N];
      int   grants;
      int   idle;
      logic pv;
      dropCnt  = '{default: 0};
      raiseCnt = '{default: 0};
      grants   = 0;
      idle     = 0;
      pv       = 1'b0;
      for (int cyc = 0; cyc < 800 && grants < 5; cyc++) begin
        tick();
        for (int i = 0; i < N; i++) begin
          if (dropCnt[i] > 0) begin
            dropCnt[i]--;
            if (dropCnt[i] == 0) begin
              req[i]      = 1'b0;
              raiseCnt[i] = 10;
            end
          end else if (raiseCnt[i] > 0) begin
            raiseCnt[i]--;
            if (raiseCnt[i] == 0) req[i] = 1'b1;
          end
        end
        if (grantValid && !pv) begin
          if (grants > 0) checkOutput("t2_idle_gap_ge2", idle >= 2, 1);
          dropCnt[grantId] = 10;
          grants++;
        end
        if (!grantValid) idle++;
        else idle = 0;
        pv = grantValid;
      end
      checkOutput("t2_grant_count", grants, 5);
    end
    applyStimulus(4'b0000, -1);
    waitRelease("t2_final_release", 20);
    repeat (5) tick();

    // Stability gate: requester 1 toggles, requester 2 waits
    applyStimulus(4'b0100, -1);
    anyValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req[1] = ~req[1];
      tick();
      if (grantValid) anyValid = 1'b1;
    end
    checkOutput("t3_no_grant_unstable", anyValid, 0);
    applyStimulus(4'b0110, 1);
    waitGrant("t3_grant_after_settle", 20);
    checkOutput("t3_winner_id", grantId, 1);
    repeat (3) tick();
    applyStimulus(4'b0100, 2);
    waitRelease("t3_release_1", 10);
    waitGrant("t3_grant_2", 30);
    checkOutput("t3_next_id", grantId, 2);
    repeat (2) tick();
    applyStimulus(4'b0000, -1);
    waitRelease("t3_release_2", 10);
    repeat (5) tick();

    // Watchdog: requester 3 holds too long
    tcBefore = toCount;
    applyStimulus(4'b1000, 3);
    waitGrant("t4_grant", 20);
    held = 1;
    for (int i = 0; i < 40 && grantValid; i++) begin
      tick();
      if (grantValid) held++;
    end
    checkOutput("t4_held_cycles", held, MAXG);
    checkOutput("t4_timeout_pulse", timeout, 1);
    checkOutput("t4_lockout_set", lockout, 4'b1000);
    tick();
    checkOutput("t4_timeout_one_cycle", timeout, 0);
    anyValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grantValid) anyValid = 1'b1;
    end
    checkOutput("t4_excluded_while_held", anyValid, 0);
    checkOutput("t4_lockout_held", lockout, 4'b1000);
    checkOutput("t4_timeout_count", toCount - tcBefore, 1);
    applyStimulus(4'b0000, -1);
    repeat (4) tick();
    checkOutput("t4_lockout_cleared", lockout, 0);
    applyStimulus(4'b1000, 3);
    waitGrant("t4_regrant", 20);
    checkOutput("t4_regrant_id", grantId, 3);
    repeat (2) tick();
    applyStimulus(4'b0000, -1);
    waitRelease("t4_release", 10);
    repeat (5) tick();

    // Release coincides with the watchdog limit: release wins
    tcBefore = toCount;
    applyStimulus(4'b0001, 0);
    waitGrant("t5_grant", 20);
    repeat (13) tick();
    applyStimulus(4'b0000, -1);
    tick();
    tick();
    checkOutput("t5_hold_t15", grantValid, 1);
    tick();
    checkOutput("t5_release_t16", grantValid, 0);
    checkOutput("t5_no_timeout", timeout, 0);
    checkOutput("t5_no_lockout", lockout, 0);
    tick();
    checkOutput("t5_no_timeout_late", timeout, 0);
    checkOutput("t5_timeout_count", toCount - tcBefore, 0);
    repeat (5) tick();

    // Asynchronous reset in the middle of a grant
    applyStimulus(4'b1000, 3);
    waitGrant("t6_grant3", 20);
    waitRelease("t6_timeout", 30);
    checkOutput("t6_lockout_before", lockout, 4'b1000);
    applyStimulus(4'b1010, 1);
    waitGrant("t6_grant1", 30);
    checkOutput("t6_grant1_id", grantId, 1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_grant", grant, 0);
    checkOutput("t6_async_valid", grantValid, 0);
    checkOutput("t6_async_id", grantId, 0);
    checkOutput("t6_async_lockout", lockout, 0);
    tick();
    tick();
    applyStimulus(4'b1111, 0);
    rst = 1'b0;
    waitGrant("t6_post_reset_grant", 20);
    checkOutput("t6_post_reset_id", grantId, 0);
    repeat (2) tick();
    applyStimulus(4'b0000, -1);
    waitRelease("t6_release", 10);
    repeat (3) tick();
    checkOutput("sb_drained", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
